// File: rtl/sdff_vc_pkg.sv
// sdff_vc_pkg: shared check indices, event layout and helpers for the scan-flop violation capture
package sdff_vc_pkg;
  localparam int CHK_D = 0;
  localparam int CHK_TI = 1;
  localparam int CHK_TE = 2;
  localparam int NCHK = 3;
  localparam int STAMP_W_DEF = 16;
  localparam int EV_W = NCHK + STAMP_W_DEF;
  typedef struct packed {
    logic [NCHK-1:0] mask;
    logic [STAMP_W_DEF-1:0] stamp;
  } ev_t;
  function automatic logic [1:0] popcnt3(input logic [NCHK-1:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction
endpackage

// File: rtl/sdff_vc_fifo.sv
// sdff_vc_fifo: sync FIFO (clk, rst_n async low; i_push/i_data in, i_pop out; o_data head, o_full, o_empty)
module sdff_vc_fifo #(
  parameter int W = 19,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_wr, w_rd;
  assign o_empty = r_wp == r_rp;
  assign o_full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_rd = i_pop & !o_empty;
  // a full FIFO still accepts a write when a read frees a slot in the same cycle
  assign w_wr = i_push & (!o_full | w_rd);
  assign o_data = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= r_wp + (AW+1)'(w_wr);
      r_rp <= r_rp + (AW+1)'(w_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/sdff_violation_capture.sv
// sdff_violation_capture: scan-mux capture with notifier-driven corruption flag, event FIFO, counter (CP/CDN clock/reset; dD/dTI/dTE data; NTF_* notifiers; Q/QX capture; EV_* event stream; VIO_CNT/OVF status)
module sdff_violation_capture
  import sdff_vc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STAMP_W = 16,
  parameter int CNT_W = 8
) (
  input  logic               CP,
  input  logic               CDN,
  input  logic               dD,
  input  logic               dTI,
  input  logic               dTE,
  input  logic               NTF_D,
  input  logic               NTF_TI,
  input  logic               NTF_TE,
  input  logic               CLR,
  output logic               Q,
  output logic               QX,
  output logic               EV_VALID,
  input  logic               EV_READY,
  output logic [NCHK-1:0]    EV_MASK,
  output logic [STAMP_W-1:0] EV_STAMP,
  output logic [CNT_W-1:0]   VIO_CNT,
  output logic               OVF
);
  logic [NCHK-1:0] w_nf, r_nf_q, w_tog;
  logic r_prime;
  logic [STAMP_W-1:0] r_stamp;
  logic w_te0, w_te1, w_xsel, w_push, w_pop, w_full, w_empty, w_drop;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W:0] w_sum;
  // X/Z on a notifier reads as 0 so an unknown notifier never fakes a toggle
  assign w_nf[CHK_D] = (NTF_D === 1'b1);
  assign w_nf[CHK_TI] = (NTF_TI === 1'b1);
  assign w_nf[CHK_TE] = (NTF_TE === 1'b1);
  assign w_tog = r_prime ? (w_nf ^ r_nf_q) : '0;
  assign w_te0 = (dTE === 1'b0);
  assign w_te1 = (dTE === 1'b1);
  // unknown select only matters when the two mux inputs disagree
  assign w_xsel = !w_te0 && !w_te1 && (dD !== dTI);
  assign w_push = |w_tog;
  assign EV_VALID = !w_empty;
  assign w_pop = EV_VALID & EV_READY;
  assign w_drop = w_push & w_full & !w_pop;
  assign w_base = CLR ? '0 : VIO_CNT;
  assign w_sum = {1'b0, w_base} + (CNT_W+1)'(popcnt3(w_tog));
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      r_nf_q <= '0;
      r_prime <= 1'b0;
      r_stamp <= '0;
      Q <= 1'b0;
      QX <= 1'b0;
      VIO_CNT <= '0;
      OVF <= 1'b0;
    end else begin
      r_nf_q <= w_nf;
      r_prime <= 1'b1;
      r_stamp <= r_stamp + 1'b1;
      Q <= w_te0 ? dD : w_te1 ? dTI : (w_xsel ? 1'b0 : dD);
      QX <= w_xsel | (w_tog[CHK_D] & w_te0) | (w_tog[CHK_TI] & w_te1) | w_tog[CHK_TE];
      VIO_CNT <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      OVF <= (OVF & !CLR) | w_drop;
    end
  end
  sdff_vc_fifo #(.W(NCHK + STAMP_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CP),
    .rst_n(CDN),
    .i_push(w_push),
    .i_data({w_tog, r_stamp}),
    .i_pop(w_pop),
    .o_data({EV_MASK, EV_STAMP}),
    .o_full(w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_sdff_violation_capture.sv
// tb_sdff_violation_capture: directed stimulus, queue-based reference model checked every cycle plus literal pins
module tb_sdff_violation_capture;
  localparam int DEPTH = 4;
  logic CP, CDN, dD, dTI, dTE, NTF_D, NTF_TI, NTF_TE, CLR, EV_READY;
  logic Q, QX, EV_VALID, OVF;
  logic [2:0] EV_MASK;
  logic [15:0] EV_STAMP;
  logic [7:0] VIO_CNT;
  int errs = 0;
  int checks = 0;
  bit [18:0] mq_fifo[$];
  bit [2:0] mprev, mtog, mnf;
  bit mprime, movf, mxbad;
  int mcnt, mstamp, mpc;
  logic mq, mqx;

  sdff_violation_capture #(.FIFO_DEPTH(DEPTH), .STAMP_W(16), .CNT_W(8)) dut (
    .CP(CP), .CDN(CDN), .dD(dD), .dTI(dTI), .dTE(dTE),
    .NTF_D(NTF_D), .NTF_TI(NTF_TI), .NTF_TE(NTF_TE), .CLR(CLR),
    .Q(Q), .QX(QX), .EV_VALID(EV_VALID), .EV_READY(EV_READY),
    .EV_MASK(EV_MASK), .EV_STAMP(EV_STAMP), .VIO_CNT(VIO_CNT), .OVF(OVF)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CP) begin
    if (!CDN) begin
      mq_fifo.delete();
      mprev = '0; mprime = 0; movf = 0; mcnt = 0; mstamp = 0; mq = 0; mqx = 0;
    end else begin
      mnf = {NTF_TE === 1'b1, NTF_TI === 1'b1, NTF_D === 1'b1};
      mtog = mprime ? (mnf ^ mprev) : 3'b000;
      mprev = mnf;
      mprime = 1;
      if (mq_fifo.size() > 0 && EV_READY === 1'b1) void'(mq_fifo.pop_front());
      if (CLR === 1'b1) begin mcnt = 0; movf = 0; end
      if (mtog != 0) begin
        if (mq_fifo.size() < DEPTH) mq_fifo.push_back({mtog, 16'(mstamp)});
        else movf = 1;
      end
      mpc = int'(mtog[0]) + int'(mtog[1]) + int'(mtog[2]);
      mcnt = (mcnt + mpc > 255) ? 255 : mcnt + mpc;
      mxbad = 0;
      if (dTE === 1'b0) mq = dD;
      else if (dTE === 1'b1) mq = dTI;
      else if (dD === dTI) mq = dD;
      else begin mq = 0; mxbad = 1; end
      mqx = mxbad | (mtog[0] && dTE === 1'b0) | (mtog[1] && dTE === 1'b1) | mtog[2];
      mstamp = (mstamp + 1) % 65536;
    end
    #1;
    chk("m_q", Q, mq);
    chk("m_qx", QX, mqx);
    chk("m_valid", EV_VALID, mq_fifo.size() > 0);
    chk("m_cnt", VIO_CNT, mcnt);
    chk("m_ovf", OVF, movf);
    if (mq_fifo.size() > 0) begin
      chk("m_mask", EV_MASK, mq_fifo[0][18:16]);
      chk("m_stamp", EV_STAMP, mq_fifo[0][15:0]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CP); @(negedge CP); end
  endtask

  initial begin
    CDN = 0; dD = 0; dTI = 0; dTE = 0; CLR = 0; EV_READY = 0;
    NTF_D = 1'bx; NTF_TI = 1'bx; NTF_TE = 1'bx;
    tick(2);
    chk("rst_q", Q, 0); chk("rst_valid", EV_VALID, 0); chk("rst_cnt", VIO_CNT, 0); chk("rst_ovf", OVF, 0);
    CDN = 1; dTE = 0; dD = 1;
    tick();
    chk("cap_q", Q, 1); chk("cap_qx", QX, 0); chk("cap_valid", EV_VALID, 0); chk("cap_cnt", VIO_CNT, 0);
    NTF_D = 0; NTF_TI = 0; NTF_TE = 0;
    tick();
    chk("xnf_valid", EV_VALID, 0); chk("xnf_cnt", VIO_CNT, 0);
    NTF_D = 1;
    tick();
    chk("d_qx", QX, 1); chk("d_valid", EV_VALID, 1); chk("d_mask", EV_MASK, 3'b001);
    chk("d_stamp", EV_STAMP, 2); chk("d_cnt", VIO_CNT, 1);
    EV_READY = 1;
    tick();
    chk("pop_qx", QX, 0); chk("pop_valid", EV_VALID, 0);
    dTE = 1; dTI = 0; NTF_D = 0;
    tick();
    chk("dte1_q", Q, 0); chk("dte1_qx", QX, 0); chk("dte1_cnt", VIO_CNT, 2);
    chk("dte1_valid", EV_VALID, 1); chk("dte1_mask", EV_MASK, 3'b001);
    NTF_D = 1; NTF_TI = 1; NTF_TE = 1;
    tick();
    chk("all_mask", EV_MASK, 3'b111); chk("all_cnt", VIO_CNT, 5); chk("all_qx", QX, 1);
    CLR = 1;
    tick();
    chk("clr_cnt", VIO_CNT, 0); chk("clr_valid", EV_VALID, 0);
    CLR = 0; EV_READY = 0; dTE = 0;
    repeat (5) begin NTF_D = ~NTF_D; tick(); end
    chk("ovf_flag", OVF, 1); chk("ovf_cnt", VIO_CNT, 5); chk("ovf_mask", EV_MASK, 3'b001);
    EV_READY = 1;
    tick(4);
    chk("drain_valid", EV_VALID, 0);
    dTE = 1'bx; dD = 1; dTI = 0;
    tick();
    dTI = 1;
    tick();
    dTE = 0;
    CLR = 1; NTF_TI = ~NTF_TI;
    tick();
    chk("clrtog_cnt", VIO_CNT, 1); chk("clrtog_ovf", OVF, 0);
    CLR = 0; EV_READY = 0;
    repeat (3) begin NTF_D = ~NTF_D; tick(); end
    EV_READY = 1; NTF_D = ~NTF_D;
    tick();
    chk("fpp_ovf", OVF, 0); chk("fpp_cnt", VIO_CNT, 5); chk("fpp_valid", EV_VALID, 1);
    NTF_D = 0;
    tick(5);
    EV_READY = 0;
    repeat (2) begin NTF_D = ~NTF_D; tick(); end
    chk("mid_valid", EV_VALID, 1);
    NTF_D = 1'bx; NTF_TE = 1'bx; CDN = 0;
    tick();
    chk("midrst_valid", EV_VALID, 0); chk("midrst_cnt", VIO_CNT, 0); chk("midrst_q", Q, 0);
    NTF_D = 1; NTF_TE = 1; CDN = 1;
    tick();
    chk("rel1_valid", EV_VALID, 0); chk("rel1_cnt", VIO_CNT, 0);
    tick();
    chk("rel2_valid", EV_VALID, 0); chk("rel2_cnt", VIO_CNT, 0);
    EV_READY = 1;
    repeat (90) begin NTF_D = ~NTF_D; NTF_TI = ~NTF_TI; NTF_TE = ~NTF_TE; tick(); end
    chk("sat_cnt", VIO_CNT, 255);
    tick();
    chk("sat_hold", VIO_CNT, 255);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
